// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage of a classic five-stage MIPS pipeline.
//
// Holds the fetch PC and the IF/ID pipeline register. The instruction
// memory is read combinationally at imem_addr (a copy of pc). The word that
// comes back is captured into IF/ID on the next rising edge, together with
// its fetch address + 4. In the same edge, pc takes the next-PC value that
// decode selects.
//
// Parameters
//   RESET_PC    fetch address after reset (word aligned).
//   DELAY_SLOT  1: the instruction fetched in a redirect cycle is the branch
//                  delay slot and proceeds normally.
//               0: that instruction is squashed into a bubble.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   stall       hold request from decode hazard logic (freezes pc and IF/ID)
//   pcsource    next-PC select: 00 pc+4, 01 jr, 10 taken branch, 11 j/jal
//   rpc         jr target
//   bpc         branch target
//   jpc         jump target
//   imem_addr   instruction memory address (combinational copy of pc)
//   imem_rdata  instruction word at imem_addr, same cycle
//   pc          current fetch PC register
//   id_instr    IF/ID instruction register
//   id_pc4      IF/ID fetch address + 4
//   id_valid    IF/ID holds a real instruction (0 = bubble)
//
// Handshake: there is no valid/ready pair on this block. The only flow
// control is stall. While stall is high, every register holds its value and
// pcsource is ignored. While stall is low, every edge advances the stage
// by exactly one fetch.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] rpc,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    localparam logic [1:0] PCS_SEQ    = 2'b00;
    localparam logic [1:0] PCS_JR     = 2'b01;
    localparam logic [1:0] PCS_BRANCH = 2'b10;
    localparam logic [1:0] PCS_JUMP   = 2'b11;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    // Reset PC is re-aligned so that a misconfigured parameter cannot put
    // the fetch unit on a non-word address.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        redirect;
    logic        squash;

    // Sequential address; wraps from FFFF_FFFC to 0 silently.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        target = pc_plus4;
        case (pcsource)
            PCS_SEQ:    target = pc_plus4;
            PCS_JR:     target = rpc;
            PCS_BRANCH: target = bpc;
            PCS_JUMP:   target = jpc;
            default:    target = pc_plus4;
        endcase
    end

    // The low two bits of every target are cleared, so pc stays word aligned.
    assign next_pc  = target & ALIGN_MASK;
    assign redirect = (pcsource != PCS_SEQ);

    // Squash applies only when there is no delay slot. The fetched word in a
    // redirect cycle is then on the wrong path.
    assign squash = (DELAY_SLOT == 0) && redirect;

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC_ALIGNED;
            id_instr <= NOP_WORD;
            id_pc4   <= 32'h0000_0000;
            id_valid <= 1'b0;
        end else if (!stall) begin
            pc     <= next_pc;
            id_pc4 <= pc_plus4;
            if (squash) begin
                id_instr <= NOP_WORD;
                id_valid <= 1'b0;
            end else begin
                id_instr <= imem_rdata;
                id_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// Bench for if_stage. Two instances share one stimulus stream: one has a
// delay slot and one squashes. The driver applies inputs on the falling
// edge. For each rising edge it pushes the expected post-edge state of both
// instances into their queues. A monitor pops those queues 1 ns after each
// rising edge and compares.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] rpc = '0, bpc = '0, jpc = '0;

    logic [31:0] imem_addr1, imem_rdata1, pc1, id_instr1, id_pc41;
    logic        id_valid1;
    logic [31:0] imem_addr0, imem_rdata0, pc0, id_instr0, id_pc40;
    logic        id_valid0;

    logic [31:0] mem [256];

    int n_cmp  = 0;
    int n_fail = 0;

    // Packed expectation: {pc, id_instr, id_pc4, id_valid}
    logic [96:0] exp_q1[$];
    logic [96:0] exp_q0[$];

    // Reference model state, one IF/ID copy per instance
    logic [31:0] m_pc;
    logic [31:0] m_instr1, m_pc4_1, m_instr0, m_pc4_0;
    logic        m_v1, m_v0;

    always #5 clk = ~clk;

    assign imem_rdata1 = mem[imem_addr1[9:2]];
    assign imem_rdata0 = mem[imem_addr0[9:2]];

    if_stage #(.RESET_PC(RST_PC), .DELAY_SLOT(1)) dut_ds (
        .clk(clk), .rst(rst), .stall(stall), .pcsource(pcsource),
        .rpc(rpc), .bpc(bpc), .jpc(jpc),
        .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .pc(pc1), .id_instr(id_instr1), .id_pc4(id_pc41), .id_valid(id_valid1)
    );

    if_stage #(.RESET_PC(RST_PC), .DELAY_SLOT(0)) dut_sq (
        .clk(clk), .rst(rst), .stall(stall), .pcsource(pcsource),
        .rpc(rpc), .bpc(bpc), .jpc(jpc),
        .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
        .pc(pc0), .id_instr(id_instr0), .id_pc4(id_pc40), .id_valid(id_valid0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_both(input string tag, input logic [96:0] e1, input logic [96:0] e0);
        check({tag, " ds pc"},       pc1,              e1[96:65]);
        check({tag, " ds id_instr"}, id_instr1,        e1[64:33]);
        check({tag, " ds id_pc4"},   id_pc41,          e1[32:1]);
        check({tag, " ds id_valid"}, {31'd0, id_valid1}, {31'd0, e1[0]});
        check({tag, " sq pc"},       pc0,              e0[96:65]);
        check({tag, " sq id_instr"}, id_instr0,        e0[64:33]);
        check({tag, " sq id_pc4"},   id_pc40,          e0[32:1]);
        check({tag, " sq id_valid"}, {31'd0, id_valid0}, {31'd0, e0[0]});
    endtask

    function automatic logic [96:0] reset_state();
        return {RST_PC, 32'h0, 32'h0, 1'b0};
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        m_instr1 = '0; m_pc4_1 = '0; m_v1 = 1'b0;
        m_instr0 = '0; m_pc4_0 = '0; m_v0 = 1'b0;
    endtask

    // Drive inputs now, without waiting for an edge, and queue the expected
    // state after the coming rising edge.
    task automatic apply(input logic s, input logic [1:0] ps,
                         input logic [31:0] r, input logic [31:0] b, input logic [31:0] j);
        logic [31:0] fetched, seq, tgt;
        rst = 1'b0; stall = s; pcsource = ps; rpc = r; bpc = b; jpc = j;
        if (!s) begin
            fetched = mem[m_pc[9:2]];
            seq = m_pc + 32'd4;
            tgt = (ps == 2'd1) ? r : (ps == 2'd2) ? b : (ps == 2'd3) ? j : seq;
            m_instr1 = fetched; m_pc4_1 = seq; m_v1 = 1'b1;
            m_instr0 = (ps != 2'd0) ? 32'h0 : fetched;
            m_pc4_0 = seq;
            m_v0 = (ps == 2'd0);
            m_pc = {tgt[31:2], 2'b00};
        end
        exp_q1.push_back({m_pc, m_instr1, m_pc4_1, m_v1});
        exp_q0.push_back({m_pc, m_instr0, m_pc4_0, m_v0});
    endtask

    task automatic step(input logic s, input logic [1:0] ps,
                        input logic [31:0] r, input logic [31:0] b, input logic [31:0] j);
        @(negedge clk);
        apply(s, ps, r, b, j);
    endtask

    // Monitor: one expected state per rising edge where the driver queued one
    always begin
        @(posedge clk);
        #1;
        if (exp_q1.size() != 0 && exp_q0.size() != 0)
            check_both("edge", exp_q1.pop_front(), exp_q0.pop_front());
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h2001_0005;
        model_reset();

        // Reset is visible before any clock edge
        #1;
        check_both("reset0", reset_state(), reset_state());

        // First fetch from RESET_PC, then sequential to pc=8
        @(negedge clk);
        apply(1'b0, 2'b00, 0, 0, 0);          // pc=4, id_instr=2001_0005
        step(1'b0, 2'b00, 0, 0, 0);           // pc=8
        step(1'b1, 2'b00, 0, 0, 0);           // stall 1
        step(1'b1, 2'b10, 0, 32'h200, 0);     // stall 2, redirect ignored
        step(1'b0, 2'b00, 0, 0, 0);           // pc=C, id_pc4=C
        step(1'b0, 2'b00, 0, 0, 0);           // pc=10
        step(1'b0, 2'b10, 0, 32'h40, 0);      // branch to 0x40
        step(1'b0, 2'b01, 32'h12, 0, 0);      // jr to 0x10 (low bits cleared)
        step(1'b0, 2'b11, 0, 0, 32'h103);     // j to 0x100
        step(1'b1, 2'b01, 32'h80, 0, 0);      // stall wins over jr
        step(1'b0, 2'b00, 0, 0, 0);           // pc=0x104
        step(1'b0, 2'b11, 0, 0, 32'hFFFF_FFFE); // pc=FFFF_FFFC
        step(1'b0, 2'b00, 0, 0, 0);           // wrap to 0
        step(1'b0, 2'b01, 32'h24, 0, 0);      // pc=0x24

        // Asynchronous pulse between edges, with stall and redirect active
        @(negedge clk);
        stall = 1'b1; pcsource = 2'b11; jpc = 32'h300;
        #2 rst = 1'b1;
        #1;
        check_both("async_rst", reset_state(), reset_state());
        model_reset();
        apply(1'b0, 2'b00, 0, 0, 0);          // first edge after release fetches RST_PC

        // Reset held across an edge overrides a redirect
        step(1'b0, 2'b00, 0, 0, 0);
        @(negedge clk);
        stall = 1'b0; pcsource = 2'b11; jpc = 32'h500;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_both("rst_hold", reset_state(), reset_state());
        model_reset();
        @(negedge clk);
        apply(1'b0, 2'b00, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom);
        end

        @(posedge clk);
        #2;
        check("queue_drain", exp_q1.size() + exp_q0.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
